// File: rtl/risc8_intc_pkg.sv
// risc8_intc_pkg
// Shared types and helpers for the risc8 vectored interrupt controller:
//   - COM register address map
//   - CTRL register bit positions
//   - return-LIFO entry layout (sized for the widest supported PC/channel)
//   - fixed-priority encoder (lowest set bit wins)
package risc8_intc_pkg;

    typedef enum logic [1:0] {
        INTC_MASK  = 2'd0,
        INTC_PEND  = 2'd1,
        INTC_CTRL  = 2'd2,
        INTC_CAUSE = 2'd3
    } intc_addr_t;

    localparam int CTRL_GIE     = 0;  // global interrupt enable, read/write
    localparam int CTRL_ERR_CLR = 1;  // write 1 clears err, reads 0
    localparam int CTRL_ERR     = 2;  // sticky LIFO-underflow flag, read-only

    // Entry fields are sized for the largest legal PCW/NCH. Instances with
    // narrower parameters zero-extend on push and truncate on read.
    localparam int ENTRY_PCW = 32;
    localparam int ENTRY_CHW = 8;

    typedef struct packed {
        logic [ENTRY_PCW-1:0] pc;  // PC to resume at after the handler
        logic [ENTRY_CHW-1:0] ch;  // channel whose handler is running
    } lifo_entry_t;

    // Index of the lowest set bit; 0 when no bit is set. Lower index means
    // higher priority, so scanning downward leaves the lowest index in r.
    function automatic int unsigned lowest_set(input logic [31:0] v);
        int unsigned r;
        r = 0;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) r = unsigned'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/risc8_intc_if.sv
// risc8_intc_if
// Bundles the controller's COM configuration bus, interrupt sources and
// core-side branch/return handshake.
//   master modport : the core / bus side (drives sources, COM, core_rdy, reti)
//   slave modport  : the interrupt controller
// Signals:
//   irq_src   sources, rising edge requests      cfg_we/addr/wdata  COM write
//   cfg_rdata COM read data (combinational)      core_rdy  at instruction boundary
//   pc_cur    resume PC if interrupted           reti      return-from-interrupt pulse
//   take      branch to vector this cycle        vector    handler PC
//   ret_pc    top-of-LIFO PC                     nest_lvl  LIFO depth
//   err       sticky reti-on-empty flag
interface risc8_intc_if #(
    parameter int NCH  = 8,
    parameter int WORD = 8,
    parameter int PCW  = 16,
    parameter int NEST = 4
) ();
    import risc8_intc_pkg::*;

    localparam int LW = $clog2(NEST + 1);

    logic [NCH-1:0]  irq_src;
    logic            cfg_we;
    intc_addr_t      cfg_addr;
    logic [WORD-1:0] cfg_wdata;
    logic [WORD-1:0] cfg_rdata;
    logic            core_rdy;
    logic [PCW-1:0]  pc_cur;
    logic            reti;
    logic            take;
    logic [PCW-1:0]  vector;
    logic [PCW-1:0]  ret_pc;
    logic [LW-1:0]   nest_lvl;
    logic            err;

    modport master (
        output irq_src, cfg_we, cfg_addr, cfg_wdata, core_rdy, pc_cur, reti,
        input  cfg_rdata, take, vector, ret_pc, nest_lvl, err
    );

    modport slave (
        input  irq_src, cfg_we, cfg_addr, cfg_wdata, core_rdy, pc_cur, reti,
        output cfg_rdata, take, vector, ret_pc, nest_lvl, err
    );

endinterface

// File: rtl/intc_lifo.sv
// intc_lifo
// Parametric LIFO holding the return context of interrupted code.
//   clk, rst : clock, asynchronous active-high reset (empties the stack)
//   push     : store wdata on top (ignored when full)
//   pop      : discard top entry (ignored when empty)
//   wdata    : entry to push
//   top      : current top entry, all zeros when empty
//   count    : number of stored entries
//   full     : count == DEPTH
//   empty    : count == 0
// The owner never pushes and pops in the same cycle; push takes precedence
// here only so the count logic stays well defined.
module intc_lifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               wdata,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [W-1:0]  mem_q [DEPTH];

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign count = cnt_q;

    // NOTE: every variable gets a default at the top of an always_comb so no
    // path leaves it unassigned, which would infer a latch.
    always_comb begin
        cnt_d = cnt_q;
        if (push && !full) begin
            cnt_d = cnt_q + CW'(1);
        end else if (pop && !empty) begin
            cnt_d = cnt_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    // NOTE: the storage array is deliberately not reset; only slots below
    // count are ever read, and clearing count is enough to empty the stack.
    always_ff @(posedge clk) begin
        if (push && !full) mem_q[AW'(cnt_q)] <= wdata;
    end

    assign top = empty ? '0 : mem_q[AW'(cnt_q - CW'(1))];

endmodule

// File: rtl/risc8_intc.sv
// risc8_intc
// Multi-channel vectored interrupt controller for the risc8 core.
// Latches rising edges on NCH sources into PEND, gates them with MASK and the
// priority of the running handler, and on an instruction boundary requests a
// branch to VBASE + ch*VSTRIDE while pushing the resume PC onto a return LIFO
// so higher-priority channels can nest.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : risc8_intc_if slave (COM registers, sources, core handshake)
// Registers (cfg_addr):
//   0 MASK  r/w enable per channel
//   1 PEND  pending requests, write-1-to-clear (a same-cycle rise wins)
//   2 CTRL  bit0 GIE r/w, bit1 write-1 clears err, bit2 err (read-only)
//   3 CAUSE {valid, channel of running handler}, read-only
module risc8_intc
    import risc8_intc_pkg::*;
#(
    parameter int             NCH     = 8,
    parameter int             WORD    = 8,
    parameter int             PCW     = 16,
    parameter int             NEST    = 4,
    parameter logic [PCW-1:0] VBASE   = PCW'(16'h0010),
    parameter int             VSTRIDE = 4
) (
    input  logic         clk,
    input  logic         rst,
    risc8_intc_if.slave  bus
);
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int LW  = $clog2(NEST + 1);
    localparam int EW  = $bits(lifo_entry_t);

    logic [NCH-1:0] src_q, src_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [NCH-1:0] mask_q, mask_d;
    logic           gie_q, gie_d;
    logic           err_q, err_d;

    logic [NCH-1:0] rise, prio_ok, elig;
    logic [CHW-1:0] win, top_ch;
    logic           take, pop;
    logic           wr_mask, wr_pend, wr_ctrl;

    lifo_entry_t    push_e, top_e;
    logic [LW-1:0]  lvl;
    logic           full, empty;

    intc_lifo #(
        .DEPTH (NEST),
        .W     (EW)
    ) u_lifo (
        .clk   (clk),
        .rst   (rst),
        .push  (take),
        .pop   (pop),
        .wdata (push_e),
        .top   (top_e),
        .count (lvl),
        .full  (full),
        .empty (empty)
    );

    // Entry fields wider than this instance's PCW/NCH are never read back.
    logic unused_top;
    assign unused_top = ^top_e;

    assign top_ch = top_e.ch[CHW-1:0];
    assign rise   = bus.irq_src & ~src_q;

    // A running handler only admits strictly higher-priority (lower-index)
    // channels, so a channel can re-pend while active but never pre-empt itself.
    always_comb begin
        prio_ok = '0;
        for (int i = 0; i < NCH; i++) begin
            prio_ok[i] = empty || (i < int'(top_ch));
        end
    end

    assign elig = pend_q & mask_q & prio_ok;
    assign win  = CHW'(lowest_set(32'(elig)));

    // reti has priority over take; a blocked take simply retries next cycle
    // because its PEND bit is still set.
    assign take = gie_q && bus.core_rdy && (|elig) && !full && !bus.reti;
    assign pop  = bus.reti && !empty;

    assign push_e = '{pc: ENTRY_PCW'(bus.pc_cur), ch: ENTRY_CHW'(win)};

    assign wr_mask = bus.cfg_we && (bus.cfg_addr == INTC_MASK);
    assign wr_pend = bus.cfg_we && (bus.cfg_addr == INTC_PEND);
    assign wr_ctrl = bus.cfg_we && (bus.cfg_addr == INTC_CTRL);

    always_comb begin
        src_d  = bus.irq_src;
        mask_d = mask_q;
        pend_d = pend_q;
        gie_d  = gie_q;
        err_d  = err_q;

        if (wr_mask) mask_d = bus.cfg_wdata[NCH-1:0];

        // Clears are applied first and the new rises ORed in last, so a rise
        // that coincides with a W1C or with the take of that channel survives.
        if (wr_pend) pend_d = pend_d & ~bus.cfg_wdata[NCH-1:0];
        if (take)    pend_d[win] = 1'b0;
        pend_d = pend_d | rise;

        if (wr_ctrl) begin
            gie_d = bus.cfg_wdata[CTRL_GIE];
            if (bus.cfg_wdata[CTRL_ERR_CLR]) err_d = 1'b0;
        end
        if (bus.reti && empty) err_d = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            src_q  <= '0;
            pend_q <= '0;
            mask_q <= '0;
            gie_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            src_q  <= src_d;
            pend_q <= pend_d;
            mask_q <= mask_d;
            gie_q  <= gie_d;
            err_q  <= err_d;
        end
    end

    always_comb begin
        bus.cfg_rdata = '0;
        case (bus.cfg_addr)
            INTC_MASK:  bus.cfg_rdata = WORD'(mask_q);
            INTC_PEND:  bus.cfg_rdata = WORD'(pend_q);
            INTC_CTRL: begin
                bus.cfg_rdata[CTRL_GIE] = gie_q;
                bus.cfg_rdata[CTRL_ERR] = err_q;
            end
            INTC_CAUSE: bus.cfg_rdata = WORD'({!empty, top_ch});
            default:    bus.cfg_rdata = '0;
        endcase
    end

    // With no eligible channel win is 0, so the idle vector is VBASE.
    assign bus.vector   = VBASE + PCW'(win) * PCW'(VSTRIDE);
    assign bus.take     = take;
    assign bus.ret_pc   = top_e.pc[PCW-1:0];
    assign bus.nest_lvl = lvl;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_risc8_intc.sv
// tb_risc8_intc
// Directed bench for risc8_intc: a NEST=4 instance (a) for the main flows and
// a NEST=2 instance (b) for the LIFO-full case. Expected vectors are queued
// when a request is raised and popped when the DUT takes it; pushed resume PCs
// are kept on a model stack and popped on reti.
module tb_risc8_intc;
    import risc8_intc_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    risc8_intc_if #(.NCH(8), .WORD(8), .PCW(16), .NEST(4)) a ();
    risc8_intc_if #(.NCH(8), .WORD(8), .PCW(16), .NEST(2)) b ();

    risc8_intc #(.NCH(8), .WORD(8), .PCW(16), .NEST(4)) dut_a (
        .clk (clk), .rst (rst), .bus (a.slave)
    );
    risc8_intc #(.NCH(8), .WORD(8), .PCW(16), .NEST(2)) dut_b (
        .clk (clk), .rst (rst), .bus (b.slave)
    );

    int total = 0;
    int bad   = 0;
    logic [15:0] sb_vec [$];
    logic [15:0] sb_ret [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_a(input intc_addr_t addr, input logic [7:0] data);
        a.cfg_we    = 1'b1;
        a.cfg_addr  = addr;
        a.cfg_wdata = data;
        tick();
        a.cfg_we    = 1'b0;
    endtask

    task automatic rd_a(input string tag, input intc_addr_t addr, input logic [7:0] exp);
        a.cfg_addr = addr;
        #1;
        check(tag, a.cfg_rdata, exp);
    endtask

    task automatic pulse_a(input logic [7:0] m);
        a.irq_src = a.irq_src | m;
        tick();
        a.irq_src = a.irq_src & ~m;
    endtask

    // Waits up to budget cycles for take, then checks the vector against the
    // scoreboard and records the pushed PC on the model stack.
    task automatic wait_take_a(input string tag, input logic [15:0] pc, input int budget);
        int n;
        logic [15:0] ev;
        n = 0;
        a.pc_cur   = pc;
        a.core_rdy = 1'b1;
        #1;
        while (a.take !== 1'b1 && n < budget) begin
            tick();
            #1;
            n++;
        end
        check({tag, "_take"}, a.take, 1);
        ev = sb_vec.pop_front();
        check({tag, "_vector"}, a.vector, ev);
        sb_ret.push_back(pc);
        tick();
        a.core_rdy = 1'b0;
    endtask

    task automatic reti_a(input string tag);
        logic [15:0] er;
        a.reti = 1'b1;
        #1;
        check({tag, "_take_blocked"}, a.take, 0);
        er = sb_ret.pop_back();
        check({tag, "_ret_pc"}, a.ret_pc, er);
        tick();
        a.reti = 1'b0;
    endtask

    task automatic no_take_a(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            #1;
            check(tag, a.take, 0);
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ev;
        rst = 1'b1;
        a.irq_src = '0; a.cfg_we = 1'b0; a.cfg_addr = INTC_MASK; a.cfg_wdata = '0;
        a.core_rdy = 1'b0; a.pc_cur = '0; a.reti = 1'b0;
        b.irq_src = '0; b.cfg_we = 1'b0; b.cfg_addr = INTC_MASK; b.cfg_wdata = '0;
        b.core_rdy = 1'b0; b.pc_cur = '0; b.reti = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Reset state
        check("rst_take", a.take, 0);
        check("rst_vector", a.vector, 16'h0010);
        check("rst_nest", a.nest_lvl, 0);
        check("rst_err", a.err, 0);
        check("rst_mask", a.cfg_rdata, 8'h00);
        rst = 1'b0;
        tick();

        // Single channel: PEND latency, take, vector, CAUSE, return PC
        wr_a(INTC_MASK, 8'h04);
        wr_a(INTC_CTRL, 8'h01);
        pulse_a(8'h04);
        rd_a("s1_pend", INTC_PEND, 8'h04);
        check("s1_no_take_without_rdy", a.take, 0);
        sb_vec.push_back(16'h0018);
        wait_take_a("s1", 16'h1234, 0);
        check("s1_nest1", a.nest_lvl, 1);
        rd_a("s1_cause", INTC_CAUSE, 8'h0A);
        rd_a("s1_pend_cleared", INTC_PEND, 8'h00);
        reti_a("s1_reti");
        check("s1_nest0", a.nest_lvl, 0);

        // Simultaneous ch5+ch1: ch1 first, ch5 strictly after the reti
        wr_a(INTC_MASK, 8'hFF);
        pulse_a(8'h22);
        sb_vec.push_back(16'h0014);
        wait_take_a("s2_ch1", 16'h2000, 0);
        a.core_rdy = 1'b1;
        rd_a("s2_ch5_pending", INTC_PEND, 8'h20);
        no_take_a("s2_ch5_held", 3);
        reti_a("s2_reti_ch1");
        sb_vec.push_back(16'h0024);
        wait_take_a("s2_ch5", 16'h2100, 0);
        reti_a("s2_reti_ch5");

        // Nesting: ch0 pre-empts ch3, ch6 waits for both returns
        pulse_a(8'h08);
        sb_vec.push_back(16'h001C);
        wait_take_a("s3_ch3", 16'h3000, 0);
        pulse_a(8'h01);
        sb_vec.push_back(16'h0010);
        wait_take_a("s3_ch0", 16'h3100, 0);
        check("s3_nest2", a.nest_lvl, 2);
        pulse_a(8'h40);
        a.core_rdy = 1'b1;
        no_take_a("s3_ch6_held_lvl2", 3);
        reti_a("s3_reti_ch0");
        #1;
        check("s3_ch6_held_lvl1", a.take, 0);
        check("s3_nest_after_pop", a.nest_lvl, 1);
        reti_a("s3_reti_ch3");
        sb_vec.push_back(16'h0028);
        wait_take_a("s3_ch6", 16'h3200, 0);
        reti_a("s3_reti_ch6");

        // reti with an eligible request defers the take by exactly one cycle
        pulse_a(8'h08);
        sb_vec.push_back(16'h001C);
        wait_take_a("s4_ch3", 16'h4000, 0);
        pulse_a(8'h01);
        a.core_rdy = 1'b1;
        a.pc_cur   = 16'h4100;
        reti_a("s4_reti_vs_take");
        sb_vec.push_back(16'h0010);
        wait_take_a("s4_ch0_deferred", 16'h4100, 0);
        reti_a("s4_reti_ch0");

        // PEND write-1-to-clear against a same-cycle rise: set wins
        wr_a(INTC_MASK, 8'h00);
        pulse_a(8'h80);
        tick();
        a.irq_src = 8'h80;
        wr_a(INTC_PEND, 8'h80);
        a.irq_src = 8'h00;
        rd_a("s5_w1c_vs_rise", INTC_PEND, 8'h80);
        tick();
        wr_a(INTC_PEND, 8'h80);
        rd_a("s5_w1c_alone", INTC_PEND, 8'h00);

        // reti on an empty LIFO sets err; CTRL=03 clears it
        a.reti = 1'b1;
        #1;
        check("s6_ret_pc_empty", a.ret_pc, 16'h0000);
        tick();
        a.reti = 1'b0;
        check("s6_err_set", a.err, 1);
        check("s6_nest_still0", a.nest_lvl, 0);
        rd_a("s6_ctrl_err", INTC_CTRL, 8'h05);
        wr_a(INTC_CTRL, 8'h03);
        check("s6_err_cleared", a.err, 0);
        rd_a("s6_ctrl_after_clr", INTC_CTRL, 8'h01);

        // Asynchronous reset in the middle of a handler
        wr_a(INTC_MASK, 8'hFF);
        pulse_a(8'h08);
        sb_vec.push_back(16'h001C);
        wait_take_a("s7_ch3", 16'h6000, 0);
        pulse_a(8'h02);
        a.core_rdy = 1'b1;
        #1;
        check("s7_pre_rst_take", a.take, 1);
        rst = 1'b1;
        #1;
        check("s7_rst_take", a.take, 0);
        check("s7_rst_vector", a.vector, 16'h0010);
        check("s7_rst_nest", a.nest_lvl, 0);
        check("s7_rst_err", a.err, 0);
        rd_a("s7_rst_mask", INTC_MASK, 8'h00);
        rd_a("s7_rst_pend", INTC_PEND, 8'h00);
        rd_a("s7_rst_cause", INTC_CAUSE, 8'h00);
        sb_ret.delete();
        a.core_rdy = 1'b0;
        rst = 1'b0;
        tick();

        // NEST=2: full LIFO suppresses take, request retained, taken after reti
        b.cfg_we = 1'b1; b.cfg_addr = INTC_MASK; b.cfg_wdata = 8'hFF;
        tick();
        b.cfg_addr = INTC_CTRL; b.cfg_wdata = 8'h01;
        tick();
        b.cfg_we = 1'b0;
        b.irq_src = 8'h20;
        sb_vec.push_back(16'h0024);
        tick();
        b.irq_src = 8'h00; b.core_rdy = 1'b1; b.pc_cur = 16'h5000;
        #1;
        check("b_ch5_take", b.take, 1);
        ev = sb_vec.pop_front();
        check("b_ch5_vector", b.vector, ev);
        sb_ret.push_back(16'h5000);
        b.irq_src = 8'h08;
        sb_vec.push_back(16'h001C);
        tick();
        b.irq_src = 8'h00; b.pc_cur = 16'h5100;
        #1;
        check("b_ch3_take", b.take, 1);
        ev = sb_vec.pop_front();
        check("b_ch3_vector", b.vector, ev);
        sb_ret.push_back(16'h5100);
        tick();
        b.irq_src = 8'h02;
        sb_vec.push_back(16'h0014);
        tick();
        b.irq_src = 8'h00;
        #1;
        check("b_full_nest", b.nest_lvl, 2);
        check("b_full_no_take", b.take, 0);
        b.cfg_addr = INTC_PEND;
        #1;
        check("b_full_pend_kept", b.cfg_rdata, 8'h02);
        tick();
        #1;
        check("b_full_no_take2", b.take, 0);
        tick();
        b.reti = 1'b1;
        #1;
        check("b_reti_take_blocked", b.take, 0);
        ev = sb_ret.pop_back();
        check("b_reti_ret_pc", b.ret_pc, ev);
        tick();
        b.reti = 1'b0; b.pc_cur = 16'h5200;
        #1;
        check("b_ch1_take", b.take, 1);
        ev = sb_vec.pop_front();
        check("b_ch1_vector", b.vector, ev);
        sb_ret.push_back(16'h5200);
        tick();
        b.core_rdy = 1'b0;
        check("b_nest_refilled", b.nest_lvl, 2);
        b.reti = 1'b1;
        #1;
        ev = sb_ret.pop_back();
        check("b_reti2_ret_pc", b.ret_pc, ev);
        tick();
        b.reti = 1'b0;
        check("b_nest_after_reti2", b.nest_lvl, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
